round_robin_arbiter: RTL and testbench
======================================

ROUND_ROBIN_ARBITER -- requirements
Module: round_robin_arbiter

Interface
REQ-001 Parameter WORD_SIZE, default 10, SHALL be the width of each FIFO word; bits [WORD_SIZE-1:WORD_SIZE-2] are the destination and bits [WORD_SIZE-3:0] are the data.
REQ-002 Parameter NUM_IN, default 4, SHALL be the number of upstream FIFOs served.
REQ-003 Parameter NUM_OUT, default 4, SHALL be the number of downstream FIFOs; it equals 2^2.
REQ-004 Port: clk, input, 1, the single clock; all state is updated on its rising edge.
REQ-005 Port: reset, input, 1, asynchronous, active-high.
REQ-006 Port: in_empty, input, NUM_IN, the fifo_empty flag of each upstream FIFO.
REQ-007 Port: in_data, input, NUM_IN*WORD_SIZE, the head-of-queue fifo_data_out of each upstream FIFO; slice i is [i*WORD_SIZE +: WORD_SIZE].
REQ-008 Port: in_pop, output, NUM_IN, the fifo_rd strobe to each upstream FIFO; it is combinational and one-hot or zero.
REQ-009 Port: out_almost_full, input, NUM_OUT, the almost_full flag of each downstream FIFO.
REQ-010 Port: out_push, output, NUM_OUT, the registered fifo_wr strobe to each downstream FIFO; it is one-hot or zero.
REQ-011 Port: out_data, output, WORD_SIZE, the registered word broadcast to all downstream fifo_data_in ports.
REQ-012 Port: idle, output, 1, registered; it is high while the FSM is in IDLE.

Function
REQ-013 Input i SHALL be eligible when in_empty[i]=0 and out_almost_full[dest(in_data slice i)]=0.
REQ-014 The block SHALL grant at most one eligible input per cycle, searching from (last_grant+1) mod NUM_IN upward with wrap-around.
REQ-015 in_pop[g] SHALL be asserted in the same cycle as grant g, and last_grant SHALL update to g at the following edge.
REQ-016 At the following edge, out_data SHALL load slice g unchanged and out_push SHALL be one-hot at dest(slice g), giving one cycle of latency; with no grant, out_push SHALL be 0 and out_data SHALL hold its value.
REQ-017 The FSM SHALL have the states IDLE (all inputs empty), ACTIVE (a grant occurs this cycle) and BLOCKED (at least one input is non-empty and none is eligible). The state is re-evaluated from the inputs at every edge, and any state can go to any state.
REQ-018 No grant SHALL be made in IDLE or BLOCKED, and last_grant SHALL hold in those states.
REQ-019 Flags that change in a cycle SHALL take effect for the grant in that same cycle.
REQ-020 Throughput SHALL be one word per cycle while any input is eligible, and the block SHALL support back-to-back grants of the same input when it is the only eligible one.

Reset
REQ-021 While reset is high: in_pop=0, out_push=0, out_data=0, last_grant=NUM_IN-1 (so input 0 has first priority), FSM=IDLE, idle=1.
REQ-022 A reset that arrives mid-transfer SHALL drop any pending out_push without completing it.
REQ-023 The first grant is allowed at the first rising edge after reset deasserts.

Configuration
REQ-024 With ARB_STATS_EN defined, the block SHALL add an output pkt_count of width NUM_OUT*8, holding one wrapping 8-bit counter per destination; each counter increments on its out_push and clears on reset.
REQ-025 Without ARB_STATS_EN, the pkt_count port and its counters SHALL be absent, and all other behaviour is identical.

Structure
REQ-026 The shared package arb_pkg SHALL hold WORD_SIZE, the destination bit positions and the state enum {IDLE, ACTIVE, BLOCKED}.
REQ-027 The sub-module rr_grant SHALL hold the combinational rotate-priority search (eligibility vector plus last_grant in, one-hot grant and valid out).

Verification
REQ-028 Test: reset, then all in_empty=1 -> idle=1, in_pop=0 and out_push=0 for 10 cycles.
REQ-029 Test: inputs 0–3 are non-empty with dests 3, 2, 1, 0 and no almost_full flags -> grants in the order 0, 1, 2, 3, 0; out_push sequence 1000, 0100, 0010, 0001 appears one cycle after each pop.
REQ-030 Test: input 1 holds 0x2A5 (dest 2) and out_almost_full=0100 -> no pop and the state is BLOCKED; clear the flag -> in_pop=0010, then out_data=0x2A5 and out_push=0100.
REQ-031 Test: only input 2 is non-empty for 5 words -> in_pop[2] is high for 5 consecutive cycles and 5 consecutive out_push pulses follow.
REQ-032 Test: assert reset one cycle after a pop -> out_push stays 0, and the first grant after release goes to input 0.
REQ-033 Test: with ARB_STATS_EN defined, push 300 words to dest 1 -> pkt_count[15:8]=44 (300 wraps modulo 256) and the other counters are 0.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin arbiter: word layout and FSM state encoding.
package arb_pkg;

  localparam int WORD_SIZE = 10;
  localparam int DEST_W    = 2;
  localparam int DEST_HI   = WORD_SIZE - 1;
  localparam int DEST_LO   = WORD_SIZE - DEST_W;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACTIVE  = 2'd1,
    BLOCKED = 2'd2
  } state_e;

endpackage

// File: rtl/rr_grant.sv
// Combinational rotate-priority search: picks the first eligible requester
// after the last granted one, wrapping around.
module rr_grant #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  elig_i,
  input  logic [IW-1:0] last_i,
  output logic [N-1:0]  grant_o,
  output logic          valid_o
);

  logic [IW-1:0] idx;
  logic          found;

  // Offsets 1..N visit every requester once, ending on last_i itself so a
  // lone eligible requester can be granted back-to-back.
  always_comb begin
    grant_o = '0;
    found   = 1'b0;
    idx     = '0;
    for (int off = 1; off <= N; off++) begin
      idx = IW'((int'(last_i) + off) % N);
      if (!found && elig_i[idx]) begin
        grant_o[idx] = 1'b1;
        found        = 1'b1;
      end
    end
  end

  assign valid_o = found;

endmodule

// File: rtl/round_robin_arbiter.sv
// Round-robin arbiter moving words from NUM_IN upstream FIFOs to NUM_OUT downstream FIFOs.
// Optional per-destination packet counters are enabled with ARB_STATS_EN.
module round_robin_arbiter #(
  parameter int WORD_SIZE = arb_pkg::WORD_SIZE,
  parameter int NUM_IN    = 4,
  parameter int NUM_OUT   = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_IN-1:0]           in_empty,
  input  logic [NUM_IN*WORD_SIZE-1:0] in_data,
  output logic [NUM_IN-1:0]           in_pop,
  input  logic [NUM_OUT-1:0]          out_almost_full,
  output logic [NUM_OUT-1:0]          out_push,
  output logic [WORD_SIZE-1:0]        out_data,
`ifdef ARB_STATS_EN
  output logic [NUM_OUT*8-1:0]        pkt_count,
`endif
  output logic                        idle
);

  import arb_pkg::*;

  localparam int IW = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

  logic [DEST_W-1:0]    dest [NUM_IN];
  logic [NUM_IN-1:0]    elig;
  logic [NUM_IN-1:0]    grant;
  logic                 grantValid;
  logic [WORD_SIZE-1:0] selWord;
  logic [IW-1:0]        grantIdx;

  state_e               state_d, state_q;
  logic [IW-1:0]        lastGrant_q;
  logic [NUM_OUT-1:0]   outPush_d, outPush_q;
  logic [WORD_SIZE-1:0] outData_q;

  for (genvar i = 0; i < NUM_IN; i++) begin : g_elig
    assign dest[i] = in_data[i*WORD_SIZE + WORD_SIZE - DEST_W +: DEST_W];
    assign elig[i] = ~in_empty[i] & ~out_almost_full[dest[i]];
  end

  rr_grant #(.N(NUM_IN), .IW(IW)) u_grant (
    .elig_i (elig),
    .last_i (lastGrant_q),
    .grant_o(grant),
    .valid_o(grantValid)
  );

  always_comb begin
    selWord  = '0;
    grantIdx = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (grant[i]) begin
        selWord  = in_data[i*WORD_SIZE +: WORD_SIZE];
        grantIdx = IW'(i);
      end
    end
  end

  // The pop strobe is the raw grant, so it must be forced low while reset is held.
  assign in_pop = reset ? '0 : grant;

  always_comb begin
    if (&in_empty) begin
      state_d = IDLE;
    end else if (grantValid) begin
      state_d = ACTIVE;
    end else begin
      state_d = BLOCKED;
    end
    outPush_d = grantValid ? (NUM_OUT'(1) << selWord[WORD_SIZE-1 -: DEST_W]) : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      lastGrant_q <= IW'(NUM_IN - 1);
      outPush_q   <= '0;
      outData_q   <= '0;
    end else begin
      state_q   <= state_d;
      outPush_q <= outPush_d;
      if (grantValid) begin
        outData_q   <= selWord;
        lastGrant_q <= grantIdx;
      end
    end
  end

  assign out_push = outPush_q;
  assign out_data = outData_q;
  assign idle     = (state_q == IDLE);

`ifdef ARB_STATS_EN
  logic [NUM_OUT*8-1:0] pktCnt_q;

  // Counters advance on the same edge that raises the matching out_push.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pktCnt_q <= '0;
    end else begin
      for (int j = 0; j < NUM_OUT; j++) begin
        if (outPush_d[j]) begin
          pktCnt_q[j*8 +: 8] <= pktCnt_q[j*8 +: 8] + 8'd1;
        end
      end
    end
  end

  assign pkt_count = pktCnt_q;
`endif

endmodule

// File: tb/tb_round_robin_arbiter.sv
// Self-checking bench for round_robin_arbiter: bench-side FIFOs, a behavioural
// round-robin model checked every cycle, and directed literal scenarios.
module tb_round_robin_arbiter;

  localparam int WS = 10;
  localparam int NI = 4;
  localparam int NO = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [NI-1:0]    in_empty;
  logic [NI*WS-1:0] in_data;
  logic [NI-1:0]    in_pop;
  logic [NO-1:0]    out_almost_full;
  logic [NO-1:0]    out_push;
  logic [WS-1:0]    out_data;
  logic             idle;
`ifdef ARB_STATS_EN
  logic [NO*8-1:0]  pkt_count;
`endif

  int checks = 0;
  int errors = 0;
  bit chkEn  = 1'b0;

  logic [WS-1:0] fq [NI][$];

  int            mLast;
  logic [NO-1:0] mPush;
  logic [WS-1:0] mData;
  logic          mIdle;

  round_robin_arbiter #(.WORD_SIZE(WS), .NUM_IN(NI), .NUM_OUT(NO)) dut (
    .clk            (clk),
    .reset          (reset),
    .in_empty       (in_empty),
    .in_data        (in_data),
    .in_pop         (in_pop),
    .out_almost_full(out_almost_full),
    .out_push       (out_push),
    .out_data       (out_data),
`ifdef ARB_STATS_EN
    .pkt_count      (pkt_count),
`endif
    .idle           (idle)
  );

  always #5 clk = ~clk;

  // First requester after 'last' (wrapping) that is non-empty and whose destination has room.
  function automatic int pickGrant(input logic [NI-1:0] emp, input logic [NI*WS-1:0] data,
                                   input logic [NO-1:0] af, input int last);
    for (int k = 1; k <= NI; k++) begin
      int c;
      c = (last + k) % NI;
      if (!emp[c] && !af[data[c*WS + WS - 2 +: 2]]) return c;
    end
    return -1;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic driveInputs();
    for (int i = 0; i < NI; i++) begin
      if (fq[i].size() == 0) begin
        in_empty[i]        = 1'b1;
        in_data[i*WS +: WS] = WS'($urandom);
      end else begin
        in_empty[i]        = 1'b0;
        in_data[i*WS +: WS] = fq[i][0];
      end
    end
  endtask

  // Samples outputs at the falling edge, then retires popped words after the rising edge.
  task automatic applyStimulus(output logic [NI-1:0] popS, output logic [NO-1:0] pushS,
                               output logic [WS-1:0] dataS, output logic idleS);
    @(negedge clk);
    popS  = in_pop;
    pushS = out_push;
    dataS = out_data;
    idleS = idle;
    @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) begin
      if (popS[i] && fq[i].size() > 0) void'(fq[i].pop_front());
    end
    driveInputs();
  endtask

  task automatic doReset();
    reset = 1'b1;
    for (int i = 0; i < NI; i++) fq[i].delete();
    out_almost_full = '0;
    driveInputs();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic drain(input int bound);
    logic [NI-1:0] p;
    logic [NO-1:0] u;
    logic [WS-1:0] d;
    logic          id;
    int            n;
    int            left;
    n = 0;
    left = fq[0].size() + fq[1].size() + fq[2].size() + fq[3].size();
    while (left > 0 && n < bound) begin
      applyStimulus(p, u, d, id);
      n++;
      left = fq[0].size() + fq[1].size() + fq[2].size() + fq[3].size();
    end
    checkOutput("drain_words_left", left, 0);
  endtask

  // Behavioural reference: last grant, registered push/data and idle flag.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mLast = NI - 1;
      mPush = '0;
      mData = '0;
      mIdle = 1'b1;
    end else begin
      int g;
      g = pickGrant(in_empty, in_data, out_almost_full, mLast);
      mIdle = &in_empty;
      if (g >= 0) begin
        mLast = g;
        mData = in_data[g*WS +: WS];
        mPush = NO'(1) << in_data[g*WS + WS - 2 +: 2];
      end else begin
        mPush = '0;
      end
    end
  end

  always @(negedge clk) begin
    if (chkEn) begin
      int g;
      logic [NI-1:0] expPop;
      expPop = '0;
      g = pickGrant(in_empty, in_data, out_almost_full, mLast);
      if (!reset && g >= 0) expPop[g] = 1'b1;
      checkOutput("in_pop", in_pop, expPop);
      checkOutput("out_push", out_push, mPush);
      checkOutput("out_data", out_data, mData);
      checkOutput("idle", idle, mIdle);
    end
  end

  initial begin
    logic [NI-1:0] p;
    logic [NO-1:0] u;
    logic [WS-1:0] d;
    logic          id;
    logic [NI-1:0] pops [7];
    logic [NO-1:0] pushes [7];
    logic [WS-1:0] datas [7];
    logic [WS-1:0] w [5];
    int expPop [6]  = '{1, 2, 4, 8, 1, 0};
    int expPush [6] = '{0, 8, 4, 2, 1, 8};
    int expData [6] = '{0, 'h311, 'h222, 'h133, 'h044, 'h355};

    out_almost_full = '0;
    in_empty = '1;
    in_data = '0;
    doReset();
    chkEn = 1'b1;

    // All inputs empty after reset.
    repeat (10) begin
      applyStimulus(p, u, d, id);
      checkOutput("idle_when_empty", id, 1);
      checkOutput("pop_when_empty", p, 0);
      checkOutput("push_when_empty", u, 0);
    end

    // Four non-empty inputs with destinations 3,2,1,0.
    fq[0].push_back(10'h311);
    fq[0].push_back(10'h355);
    fq[1].push_back(10'h222);
    fq[2].push_back(10'h133);
    fq[3].push_back(10'h044);
    driveInputs();
    for (int k = 0; k < 6; k++) applyStimulus(pops[k], pushes[k], datas[k], id);
    for (int k = 0; k < 6; k++) begin
      checkOutput($sformatf("rr_pop%0d", k), pops[k], expPop[k]);
      checkOutput($sformatf("rr_push%0d", k), pushes[k], expPush[k]);
      if (k > 0) checkOutput($sformatf("rr_data%0d", k), datas[k], expData[k]);
    end

    // Blocked by almost_full, then released.
    out_almost_full = 4'b0100;
    fq[1].push_back(10'h2A5);
    driveInputs();
    applyStimulus(p, u, d, id);
    checkOutput("blocked_pop_a", p, 0);
    applyStimulus(p, u, d, id);
    checkOutput("blocked_pop_b", p, 0);
    checkOutput("blocked_not_idle", id, 0);
    out_almost_full = '0;
    applyStimulus(p, u, d, id);
    checkOutput("unblocked_pop", p, 4'b0010);
    applyStimulus(p, u, d, id);
    checkOutput("unblocked_push", u, 4'b0100);
    checkOutput("unblocked_data", d, 10'h2A5);

    // Single input streaming back-to-back.
    for (int k = 0; k < 5; k++) begin
      w[k] = WS'($urandom);
      fq[2].push_back(w[k]);
    end
    driveInputs();
    for (int k = 0; k < 7; k++) applyStimulus(pops[k], pushes[k], datas[k], id);
    for (int k = 0; k < 5; k++) begin
      checkOutput($sformatf("stream_pop%0d", k), pops[k], 4'b0100);
      checkOutput($sformatf("stream_push%0d", k), pushes[k+1], 4'b0001 << w[k][9:8]);
      checkOutput($sformatf("stream_data%0d", k), datas[k+1], w[k]);
    end
    checkOutput("stream_pop_end", pops[5], 0);
    checkOutput("stream_push_end", pushes[6], 0);

    // Reset arriving while a grant is in flight.
    doReset();
    fq[1].push_back(10'h0AA);
    fq[2].push_back(10'h1BB);
    driveInputs();
    applyStimulus(p, u, d, id);
    checkOutput("pre_reset_pop", p, 4'b0010);
    @(negedge clk);
    checkOutput("pop_before_reset", in_pop, 4'b0100);
    #1 reset = 1'b1;
    #1 checkOutput("pop_during_reset", in_pop, 0);
    @(posedge clk);
    #1 checkOutput("push_dropped", out_push, 0);
    checkOutput("data_cleared", out_data, 0);
    fq[0].push_back(10'h3CC);
    fq[3].push_back(10'h2DD);
    driveInputs();
    @(posedge clk);
    #1 reset = 1'b0;
    applyStimulus(p, u, d, id);
    checkOutput("post_reset_pop", p, 4'b0001);
    applyStimulus(p, u, d, id);
    checkOutput("post_reset_push", u, 4'b1000);
    checkOutput("post_reset_data", d, 10'h3CC);
    drain(50);

    // Randomised traffic against the model.
    for (int it = 0; it < 2000; it++) begin
      for (int i = 0; i < NI; i++) begin
        if ($urandom_range(0, 2) == 0 && fq[i].size() < 4) fq[i].push_back(WS'($urandom));
      end
      out_almost_full = ($urandom_range(0, 3) == 0) ? NO'($urandom) : '0;
      driveInputs();
      applyStimulus(p, u, d, id);
    end
    out_almost_full = '0;
    driveInputs();
    drain(100);

`ifdef ARB_STATS_EN
    doReset();
    for (int k = 0; k < 300; k++) fq[0].push_back({2'd1, 8'($urandom)});
    driveInputs();
    drain(400);
    repeat (2) applyStimulus(p, u, d, id);
    checkOutput("pkt_count_dest0", pkt_count[7:0], 0);
    checkOutput("pkt_count_dest1", pkt_count[15:8], 44);
    checkOutput("pkt_count_dest2", pkt_count[23:16], 0);
    checkOutput("pkt_count_dest3", pkt_count[31:24], 0);
`endif

    chkEn = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
